// File: rtl/pkt_buffer_mc_pkg.sv
// Shared definitions for the multi-channel packet descriptor buffer.
package pkt_buffer_mc_pkg;

  // P_SRC field starts at this bit of the descriptor; {partition, channel} live at its bottom
  localparam int unsigned P_SRC_LSB = 24;

  typedef enum logic {
    DROP_MODE_BP   = 1'b0,
    DROP_MODE_DROP = 1'b1
  } drop_mode_e;

  // Number of bits needed to represent value (0 for 0)
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned bits;
    v = value;
    bits = 0;
    while (v > 0) begin
      bits++;
      v = v >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/pkt_buffer_mc_fifo_ctrl_cnt.sv
// Per-channel FIFO control: binary pointers plus an occupancy count one bit wider than the pointers.
module fifo_ctrl_cnt #(
  parameter int LOG_DEP = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               wr,
  input  logic               rd,
  input  logic               flush,
  output logic [LOG_DEP-1:0] waddr,
  output logic [LOG_DEP-1:0] raddr,
  output logic               empty,
  output logic               full,
  output logic [LOG_DEP:0]   count,
  output logic               wen,
  output logic               ren
);

  localparam logic [LOG_DEP:0] DEPTH = {1'b1, {LOG_DEP{1'b0}}};

  assign empty = (count == '0);
  assign full  = (count == DEPTH);
  // full/empty come from pre-cycle state; a flush suppresses both sides
  assign wen   = enable & wr & ~full & ~flush;
  assign ren   = enable & rd & ~empty & ~flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      waddr <= '0;
      raddr <= '0;
      count <= '0;
    end else if (enable && flush) begin
      waddr <= '0;
      raddr <= '0;
      count <= '0;
    end else begin
      if (wen) waddr <= waddr + 1'b1;
      if (ren) raddr <= raddr + 1'b1;
      count <= count + (LOG_DEP+1)'(wen) - (LOG_DEP+1)'(ren);
    end
  end

endmodule

// File: rtl/pkt_buffer_mc.sv
// Packet descriptor buffer: one shared BRAM split into N per-channel FIFOs of depth K,
// routed by the P_SRC field, with flush, occupancy, drop policy and a registered read-valid.
module pkt_buffer_mc
  import pkt_buffer_mc_pkg::*;
#(
  parameter int PID        = 0,
  parameter int N          = 4,
  parameter int WIDTH      = 32,
  parameter int K          = 128,
  parameter int PBPART_W   = 3,
  parameter int DROP_MODE  = 0,
  parameter int DROP_CNT_W = 16,
  localparam int LOG_N     = clogb2(N - 1),
  localparam int LOG_K     = clogb2(K - 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_packet,
  output logic                      in_ack,
  input  logic [N-1:0]              flush,
  input  logic [N-1:0]              rd_select,
  output logic [WIDTH-1:0]          rd_packet,
  output logic                      rd_valid,
  output logic [N-1:0]              rd_ready,
  output logic [N*(LOG_K+1)-1:0]    occupancy,
  output logic [DROP_CNT_W-1:0]     drop_count
);

  localparam int AW      = LOG_N + LOG_K;
  localparam bit DROP_EN = (DROP_MODE == int'(DROP_MODE_DROP));

  logic [LOG_N+PBPART_W-1:0] src;
  logic [PBPART_W-1:0]       part;
  logic [LOG_N-1:0]          ch;
  logic                      match;
  logic                      drop_inc;
  logic [N-1:0]              wr_req, rd_req, wen, ren, empty, full;
  logic [LOG_K-1:0]          waddr [N];
  logic [LOG_K-1:0]          raddr [N];
  logic [LOG_K:0]            count [N];
  logic [AW-1:0]             mem_waddr, mem_raddr;
  logic [WIDTH-1:0]          mem [2**AW];

  assign src   = in_packet[P_SRC_LSB +: LOG_N+PBPART_W];
  assign part  = src[LOG_N +: PBPART_W];
  assign ch    = src[LOG_N-1:0];
  assign match = enable & in_valid & ~reset & (part == PBPART_W'(PID)) & (int'(ch) < N);

  always_comb begin
    wr_req = '0;
    for (int unsigned i = 0; i < N; i++) wr_req[i] = match && (ch == LOG_N'(i));
  end

  // Lowest set bit of rd_select wins
  assign rd_req = rd_select & (~rd_select + N'(1));

  for (genvar g = 0; g < N; g++) begin : g_ch
    fifo_ctrl_cnt #(.LOG_DEP(LOG_K)) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .wr     (wr_req[g]),
      .rd     (rd_req[g]),
      .flush  (flush[g]),
      .waddr  (waddr[g]),
      .raddr  (raddr[g]),
      .empty  (empty[g]),
      .full   (full[g]),
      .count  (count[g]),
      .wen    (wen[g]),
      .ren    (ren[g])
    );
    assign occupancy[g*(LOG_K+1) +: LOG_K+1] = count[g];
    assign rd_ready[g] = ~empty[g];
  end

  assign in_ack   = |(wr_req & ~flush & (~full | {N{DROP_EN}}));
  assign drop_inc = DROP_EN & (|(wr_req & ~flush & full));

  always_comb begin
    mem_waddr = '0;
    mem_raddr = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (wen[i]) mem_waddr = {LOG_N'(i), waddr[i]};
      if (ren[i]) mem_raddr = {LOG_N'(i), raddr[i]};
    end
  end

  always_ff @(posedge clock) begin
    if (|wen) mem[mem_waddr] <= in_packet;
    if (|ren) rd_packet <= mem[mem_raddr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid   <= 1'b0;
      drop_count <= '0;
    end else begin
      rd_valid <= |ren;
      if (drop_inc && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pkt_buffer_mc.sv
// Bench: backpressure and drop instances on shared stimulus, checked against a queue-based model.
module tb_pkt_buffer_mc;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_packet = '0;
  logic [3:0]  flush = '0;
  logic [3:0]  rd_select = '0;

  logic        ack  [2];
  logic [31:0] rdp  [2];
  logic        rv   [2];
  logic [3:0]  rdy  [2];
  logic [15:0] occ  [2];
  logic [15:0] dcnt [2];

  pkt_buffer_mc #(.PID(3), .N(4), .WIDTH(32), .K(8), .PBPART_W(3), .DROP_MODE(0), .DROP_CNT_W(16)) u_bp (
    .clock(clock), .reset(reset), .enable(enable), .in_valid(in_valid), .in_packet(in_packet),
    .in_ack(ack[0]), .flush(flush), .rd_select(rd_select), .rd_packet(rdp[0]), .rd_valid(rv[0]),
    .rd_ready(rdy[0]), .occupancy(occ[0]), .drop_count(dcnt[0])
  );

  pkt_buffer_mc #(.PID(3), .N(4), .WIDTH(32), .K(8), .PBPART_W(3), .DROP_MODE(1), .DROP_CNT_W(16)) u_dr (
    .clock(clock), .reset(reset), .enable(enable), .in_valid(in_valid), .in_packet(in_packet),
    .in_ack(ack[1]), .flush(flush), .rd_select(rd_select), .rd_packet(rdp[1]), .rd_valid(rv[1]),
    .rd_ready(rdy[1]), .occupancy(occ[1]), .drop_count(dcnt[1])
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string nm, input int m, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [dut%0d] t=%0t: got %0h, want %0h", nm, m, $time, act, exp);
    end
  endtask

  // Reference model: one queue per channel per instance
  logic [31:0] mq [2][4][$];
  int          dc [2] = '{0, 0};
  logic        erv [2] = '{1'b0, 1'b0};
  logic [31:0] erd [2];
  logic [15:0] eocc;
  logic [3:0]  erdy;
  logic [4:0]  src;
  int          sz [4];
  int          r;
  int          ch;
  bit          match, push, eack;

  always @(negedge clock) begin
    for (int m = 0; m < 2; m++) begin
      eocc = '0;
      erdy = '0;
      for (int c = 0; c < 4; c++) begin
        eocc[c*4 +: 4] = 4'(mq[m][c].size());
        erdy[c] = (mq[m][c].size() != 0);
      end
      check("occupancy", m, occ[m], eocc);
      check("rd_ready", m, rdy[m], erdy);
      check("drop_count", m, dcnt[m], 16'(dc[m]));
      check("rd_valid", m, rv[m], erv[m]);
      if (erv[m]) check("rd_packet", m, rdp[m], erd[m]);
    end

    src   = in_packet[28:24];
    ch    = int'(src[1:0]);
    match = in_valid && (src[4:2] == 3'd3);
    r = -1;
    for (int c = 3; c >= 0; c--) if (rd_select[c]) r = c;

    for (int m = 0; m < 2; m++) begin
      eack = 1'b0;
      if (reset) begin
        for (int c = 0; c < 4; c++) mq[m][c].delete();
        dc[m]  = 0;
        erv[m] = 1'b0;
      end else if (!enable) begin
        erv[m] = 1'b0;
      end else begin
        for (int c = 0; c < 4; c++) sz[c] = mq[m][c].size();
        push = 1'b0;
        if (match && !flush[ch]) begin
          if (sz[ch] < 8) begin
            eack = 1'b1;
            push = 1'b1;
          end else if (m == 1) begin
            eack = 1'b1;
            if (dc[m] < 65535) dc[m]++;
          end
        end
        erv[m] = 1'b0;
        if (r >= 0 && !flush[r] && sz[r] > 0) begin
          erd[m] = mq[m][r].pop_front();
          erv[m] = 1'b1;
        end
        if (push) mq[m][ch].push_back(in_packet);
        for (int c = 0; c < 4; c++) if (flush[c]) mq[m][c].delete();
      end
      check("in_ack", m, ack[m], eack);
    end
  end

  function automatic logic [31:0] desc(input int part, input int chn, input int pay);
    return {3'b000, 3'(part), 2'(chn), 24'(pay)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    flush     = '0;
    rd_select = '0;
    enable    = 1'b1;
  endtask

  task automatic wr(input int part, input int chn, input int pay);
    in_valid  = 1'b1;
    in_packet = desc(part, chn, pay);
    tick();
    idle();
  endtask

  initial begin
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Fill channel 2, then overflow it once
    for (int i = 0; i < 8; i++) wr(3, 2, 'h100 + i);
    check("t1_occ2", 0, occ[0][11:8], 8);
    check("t1_ready", 0, rdy[0], 4'b0100);
    wr(3, 2, 'h108);
    check("t2_occ2", 0, occ[0][11:8], 8);
    check("t2_drop", 0, dcnt[0], 0);
    check("t2_occ2", 1, occ[1][11:8], 8);
    check("t2_drop", 1, dcnt[1], 1);
    for (int i = 0; i < 8; i++) begin
      rd_select = 4'b0100;
      tick();
      idle();
      for (int m = 0; m < 2; m++) begin
        check("t1_rv", m, rv[m], 1);
        check("t1_data", m, rdp[m][23:0], 24'('h100 + i));
      end
    end
    check("t1_ready_end", 0, rdy[0], 4'b0000);

    // Write and read of an empty channel in the same cycle
    in_valid  = 1'b1;
    in_packet = desc(3, 1, 'hAA);
    rd_select = 4'b0010;
    tick();
    idle();
    check("t3_rv", 0, rv[0], 0);
    check("t3_occ1", 0, occ[0][7:4], 1);
    rd_select = 4'b0010;
    tick();
    idle();
    check("t3_rv2", 0, rv[0], 1);
    check("t3_data", 0, rdp[0][23:0], 24'hAA);

    // Flush with colliding write, then wrapping write/read pairs
    for (int i = 0; i < 3; i++) wr(3, 0, 'h200 + i);
    flush     = 4'b0001;
    in_valid  = 1'b1;
    in_packet = desc(3, 0, 'h2FF);
    tick();
    idle();
    check("t4_occ0", 0, occ[0][3:0], 0);
    check("t4_ready0", 0, rdy[0][0], 0);
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      in_packet = desc(3, 0, 'h300 + i);
      rd_select = 4'b0001;
      tick();
      idle();
      if (i > 0) check("t4_wrap", 0, rdp[0][23:0], 24'('h300 + i - 1));
    end
    rd_select = 4'b0001;
    tick();
    idle();

    // Foreign partition, then arbitration between channels 1 and 3
    wr(5, 1, 'h55);
    check("t5_foreign", 0, occ[0], 16'h0000);
    wr(3, 1, 'h11);
    wr(3, 3, 'h33);
    rd_select = 4'b1010;
    tick();
    idle();
    check("t5_data", 0, rdp[0][23:0], 24'h11);
    check("t5_occ", 0, occ[0], 16'h1000);

    // Reset mid-burst, then frozen cycles
    for (int i = 0; i < 4; i++) wr(3, 3, 'h400 + i);
    check("t6_occ3", 0, occ[0][15:12], 5);
    rd_select = 4'b1000;
    tick();
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_packet = desc(3, 3, 'h4FF);
    tick();
    reset = 1'b0;
    idle();
    for (int m = 0; m < 2; m++) begin
      check("t6_occ", m, occ[m], 0);
      check("t6_rv", m, rv[m], 0);
      check("t6_drop", m, dcnt[m], 0);
    end
    wr(3, 3, 'h500);
    wr(3, 2, 'h501);
    for (int i = 0; i < 4; i++) begin
      enable    = 1'b0;
      in_valid  = 1'b1;
      in_packet = desc(3, 3, 'h600 + i);
      rd_select = 4'b1000;
      tick();
    end
    idle();
    check("t6_frozen", 0, occ[0], 16'h1100);
    check("t6_frozen_rv", 0, rv[0], 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      enable    = ($urandom_range(0, 9) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_packet = desc(($urandom_range(0, 4) == 0) ? 5 : 3, int'($urandom_range(0, 3)), int'($urandom));
      rd_select = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      flush     = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'b0000;
      tick();
    end
    idle();
    reset = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
